// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the combinational integer ALU.
//
// Holds issued ALU/branch/JALR micro-ops until both source operands are
// known, captures operands from the ALU and LSB CDB channels, and
// dispatches the lowest-index ready entry per cycle through registered
// outputs into the ALU.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rollback                 misprediction flush (synchronous)
//   issue_*                  new micro-op from the issue stage
//   rs_full                  all entries busy (combinational)
//   cdb_alu_*, cdb_lsb_*     CDB broadcast channels
//   alu_flag/op/val1/val2/rob  registered dispatch to the ALU
//
// Optional build macro ALU_RS_STAT_EN adds stat_dispatch and stat_full
// 32-bit event counters.

module alu_rs #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rollback,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic [31:0]      issue_vj,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic             issue_qj_busy,
  input  logic [31:0]      issue_vk,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic             issue_qk_busy,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_val,
  output logic             alu_flag,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [ROB_W-1:0] alu_rob
`ifdef ALU_RS_STAT_EN
  ,
  output logic [31:0]      stat_dispatch,
  output logic [31:0]      stat_full
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] qj_busy;
  logic [DEPTH-1:0] qk_busy;
  logic [5:0]       op_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             do_issue;

  logic [31:0]      iss_vj;
  logic             iss_qj_busy;
  logic [31:0]      iss_vk;
  logic             iss_qk_busy;

  // Priority encoders: scan high to low so the lowest index wins.
  always_comb begin
    rs_full    = &busy;
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
      if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[IDX_W-1:0];
      end
    end
    do_issue = issue_valid && !rs_full && free_found;
  end

  // Same-cycle CDB bypass for the incoming micro-op; ALU channel wins.
  always_comb begin
    iss_vj      = issue_vj;
    iss_qj_busy = issue_qj_busy;
    iss_vk      = issue_vk;
    iss_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (cdb_alu_valid && cdb_alu_rob == issue_qj) begin
        iss_vj      = cdb_alu_val;
        iss_qj_busy = 1'b0;
      end else if (cdb_lsb_valid && cdb_lsb_rob == issue_qj) begin
        iss_vj      = cdb_lsb_val;
        iss_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (cdb_alu_valid && cdb_alu_rob == issue_qk) begin
        iss_vk      = cdb_alu_val;
        iss_qk_busy = 1'b0;
      end else if (cdb_lsb_valid && cdb_lsb_rob == issue_qk) begin
        iss_vk      = cdb_lsb_val;
        iss_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      qj_busy  <= '0;
      qk_busy  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
      end
      alu_flag <= 1'b0;
      alu_op   <= '0;
      alu_val1 <= '0;
      alu_val2 <= '0;
      alu_rob  <= '0;
    end else if (rollback) begin
      // Flush only; the data outputs keep their last values.
      busy     <= '0;
      alu_flag <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_rob == qj_q[i]) begin
            vj_q[i]    <= cdb_alu_val;
            qj_busy[i] <= 1'b0;
          end else if (cdb_lsb_valid && cdb_lsb_rob == qj_q[i]) begin
            vj_q[i]    <= cdb_lsb_val;
            qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_rob == qk_q[i]) begin
            vk_q[i]    <= cdb_alu_val;
            qk_busy[i] <= 1'b0;
          end else if (cdb_lsb_valid && cdb_lsb_rob == qk_q[i]) begin
            vk_q[i]    <= cdb_lsb_val;
            qk_busy[i] <= 1'b0;
          end
        end
      end

      if (sel_found) begin
        alu_flag      <= 1'b1;
        alu_op        <= op_q[sel_idx];
        alu_val1      <= vj_q[sel_idx];
        alu_val2      <= vk_q[sel_idx];
        alu_rob       <= rob_q[sel_idx];
        busy[sel_idx] <= 1'b0;
      end else begin
        alu_flag <= 1'b0;
      end

      // free_idx is never the selected entry: selection needs busy=1.
      if (do_issue) begin
        busy[free_idx]    <= 1'b1;
        op_q[free_idx]    <= issue_op;
        rob_q[free_idx]   <= issue_rob;
        vj_q[free_idx]    <= iss_vj;
        qj_q[free_idx]    <= issue_qj;
        qj_busy[free_idx] <= iss_qj_busy;
        vk_q[free_idx]    <= iss_vk;
        qk_q[free_idx]    <= issue_qk;
        qk_busy[free_idx] <= iss_qk_busy;
      end
    end
  end

`ifdef ALU_RS_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_dispatch <= '0;
      stat_full     <= '0;
    end else begin
      if (!rollback && sel_found) stat_dispatch <= stat_dispatch + 32'd1;
      if (issue_valid && rs_full) stat_full <= stat_full + 32'd1;
    end
  end
`endif

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that feeds the combinational integer ALU in the Tomasulo core.
- Holds issued ALU/branch/JALR micro-ops until both source operands are known.
- Captures operands from the two CDB broadcast channels (ALU and LSB).
- Each cycle, dispatches one ready entry through a registered interface into the ALU's val1/val2/flag/opcode/rob_reorder inputs.

Parameters:
- DEPTH, 16, number of entries (power of 2, ≥2).
- ROB_W, 4, ROB tag width; equals width of `RBID.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rollback  in  1  misprediction flush.
- issue_valid  in  1  new micro-op present.
- issue_op  in  6  ALU opcode (SUB, ADDI, BEQ, JALR, etc.).
- issue_rob  in  ROB_W  destination ROB tag.
- issue_vj  in  32  operand 1 value, valid when issue_qj_busy=0.
- issue_qj  in  ROB_W  operand 1 producer tag.
- issue_qj_busy  in  1  operand 1 pending.
- issue_vk  in  32  operand 2 value or immediate.
- issue_qk  in  ROB_W  operand 2 producer tag.
- issue_qk_busy  in  1  operand 2 pending.
- rs_full  out  1  no free entry.
- cdb_alu_valid  in  1  ALU broadcast valid.
- cdb_alu_rob  in  ROB_W  ALU broadcast tag.
- cdb_alu_val  in  32  ALU broadcast value.
- cdb_lsb_valid  in  1  LSB broadcast valid.
- cdb_lsb_rob  in  ROB_W  LSB broadcast tag.
- cdb_lsb_val  in  32  LSB broadcast value.
- alu_flag  out  1  dispatch valid (to ALU flag).
- alu_op  out  6  to ALU opcode.
- alu_val1  out  32  to ALU val1.
- alu_val2  out  32  to ALU val2.
- alu_rob  out  ROB_W  to ALU rob_reorder.

Behaviour:
- Reset (rst=0, async): all entries free; alu_flag=0; alu_op=0, alu_val1=0, alu_val2=0, alu_rob=0; rs_full=0.
- Entry fields: busy, op, rob, vj, qj, qj_busy, vk, qk, qk_busy.
- rs_full is combinational: 1 exactly when all DEPTH entries are busy at the start of the cycle.
- Issue: if issue_valid=1 and rs_full=0, write the lowest-index free entry.
  - issue_valid while rs_full=1 is ignored; the upstream must hold the micro-op.
  - Issue bypass: if an operand is pending and its tag matches a same-cycle valid CDB tag, store it as ready with that CDB value. The ALU channel has priority if both channels match.
- Wakeup: each busy entry with a pending operand whose tag matches a valid CDB tag captures the value and clears the pending bit at the clock edge.
- Select: the lowest-index busy entry with both operands ready at the start of the cycle is dispatched.
  - Outputs are registered: on the edge, alu_flag=1, alu_op/val1/val2/rob take the entry's fields, and the entry is freed.
  - If no entry is ready, alu_flag=0 and the other outputs hold their previous values.
  - The ALU result therefore appears on the CDB in the cycle after the dispatch edge.
- Latency:
  - An entry issued with both operands ready dispatches at the earliest on the edge after the one that wrote it (issue at edge N, alu_flag high after edge N+1).
  - An entry woken at edge N is eligible for select in the cycle after edge N.
- Simultaneous events:
  - Dispatch and issue in the same cycle: the issue uses only entries free at the start of the cycle. A freed slot is reusable next cycle.
  - Wakeup and dispatch in the same cycle affect different entries, because only fully ready entries are selected.
- Rollback (synchronous, highest priority): at the edge, all entries are freed, alu_flag=0, and issue and wakeup in that cycle are discarded. Data outputs are not cleared.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- Width rule: values are stored as 32-bit unsigned; signedness is resolved in the ALU by opcode.

Optional Feature:
- Macro: ALU_RS_STAT_EN.
- Defined:
  - Adds output stat_dispatch [31:0], counting dispatch edges (alu_flag written 1).
  - Adds output stat_full [31:0], counting cycles with issue_valid=1 and rs_full=1.
  - Both counters reset to 0 on rst, are not cleared by rollback, and wrap at 2^32.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Ready issue: issue ADD, vj=5, vk=7, no busy bits → one cycle after the issue edge, alu_flag=1, alu_op=ADD, alu_val1=5, alu_val2=7, alu_rob=issue_rob. Next cycle alu_flag=0.
- Wakeup: issue SUB, qj_busy=1, qj=3, vk=1; later cdb_lsb_valid=1, cdb_lsb_rob=3, cdb_lsb_val=10 → the following cycle dispatches val1=10, val2=1; no dispatch before the broadcast.
- Issue bypass: issue with qk_busy=1, qk=2 in the same cycle as cdb_alu_valid=1, rob=2, val=0xFFFFFFFF → dispatch next cycle with alu_val2=0xFFFFFFFF.
- Full: 16 issues with qj pending on tag 9 → rs_full=1, and a 17th issue is dropped. Broadcasting tag 9 yields 16 consecutive dispatches in index order, then rs_full=0.
- Rollback: 4 ready entries, rollback asserted on the first dispatch cycle → alu_flag=0 after that edge, no further dispatches, rs_full=0.
- Async reset: rst=0 between clock edges with entries pending → alu_flag drops immediately, and no dispatch occurs after rst returns to 1.
